// File: rtl/vga_sync_checker.sv
// Raster observer: registers sync/colour taps, measures line/frame timing, reports lock and sticky errors two clocks after the pixel.
// Build macro VGA_COLOUR_CAPTURE_EN adds the mid-screen colour capture on colour_o (tied to zero otherwise).
module vga_sync_checker #(
   parameter int H_TOTAL  = 800,
   parameter int H_SYNC   = 96,
   parameter int H_START  = 144,
   parameter int H_ACTIVE = 640,
   parameter int V_TOTAL  = 525,
   parameter int V_SYNC   = 2,
   parameter int V_START  = 35,
   parameter int V_ACTIVE = 480,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk_main,
   input  logic       rst,
   input  logic       hsync_i,
   input  logic       vsync_i,
   input  logic       red_i,
   input  logic       green_i,
   input  logic       blue_i,
   input  logic       clr_i,
   output logic       locked_o,
   output logic       h_err_o,
   output logic       v_err_o,
   output logic       blank_err_o,
   output logic [7:0] frame_cnt_o,
   output logic [2:0] colour_o
);

   localparam int HW = 11;
   localparam int VW = 10;

   localparam logic [HW-1:0] H_MAX    = '1;
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_TOT    = HW'(H_TOTAL);
   localparam logic [HW-1:0] H_SW     = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_LO = HW'(H_START);
   localparam logic [HW-1:0] H_ACT_HI = HW'(H_START + H_ACTIVE);

   localparam logic [VW-1:0] V_MAX    = '1;
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_TOT    = VW'(V_TOTAL);
   localparam logic [VW-1:0] V_SW     = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_LO = VW'(V_START);
   localparam logic [VW-1:0] V_ACT_HI = VW'(V_START + V_ACTIVE);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            hs_q, hs_d;
   logic            vs_q, vs_d;
   logic            hs_prev_q, hs_prev_d;
   logic            vs_prev_q, vs_prev_d;
   logic [2:0]      rgb_q, rgb_d;
   logic            clr_q, clr_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [VW-1:0]   vcnt_q, vcnt_d;
   logic            locked_q, locked_d;
   logic            h_err_q, h_err_d;
   logic            v_err_q, v_err_d;
   logic            blank_err_q, blank_err_d;
   logic [7:0]      frame_cnt_q, frame_cnt_d;

   logic            h_as, h_de, v_as, v_de;
   logic            checks_on;
   logic            v_len_ok;
   logic            h_ev, v_ev, blank_ev;
   logic            in_active;

   // Edges are seen between the first register stage and its delayed copy.
   assign h_as = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
   assign h_de = (hs_q != SYNC_POL) && (hs_prev_q == SYNC_POL);
   assign v_as = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
   assign v_de = (vs_q != SYNC_POL) && (vs_prev_q == SYNC_POL);

   assign checks_on = (state_q != SEARCH);
   assign v_len_ok  = (vcnt_q == V_LAST);

   always_comb begin
      hs_d      = hsync_i;
      vs_d      = vsync_i;
      rgb_d     = {red_i, green_i, blue_i};
      clr_d     = clr_i;
      hs_prev_d = hs_q;
      vs_prev_d = vs_q;

      if (h_as) begin
         hcnt_d = '0;
      end else if (hcnt_q == H_MAX) begin
         hcnt_d = H_MAX;
      end else begin
         hcnt_d = hcnt_q + 1'b1;
      end

      if (v_as) begin
         vcnt_d = '0;
      end else if (h_as && (vcnt_q != V_MAX)) begin
         vcnt_d = vcnt_q + 1'b1;
      end else begin
         vcnt_d = vcnt_q;
      end
   end

   // hcnt_d/vcnt_d are the coordinates of the pixel currently in the first register stage.
   always_comb begin
      h_ev = 1'b0;
      v_ev = 1'b0;
      if (checks_on) begin
         if (h_as && (hcnt_q != H_LAST)) h_ev = 1'b1;
         if (hcnt_d == H_TOT)            h_ev = 1'b1;
         if (h_de && (hcnt_d != H_SW))   h_ev = 1'b1;
         if (v_as && !v_len_ok)          v_ev = 1'b1;
         if (h_as && !v_as && (vcnt_d == V_TOT)) v_ev = 1'b1;
         if (v_de && (vcnt_d != V_SW))   v_ev = 1'b1;
      end
   end

   assign in_active = (hcnt_d >= H_ACT_LO) && (hcnt_d < H_ACT_HI) &&
                      (vcnt_d >= V_ACT_LO) && (vcnt_d < V_ACT_HI);
   assign blank_ev  = (state_q == LOCKED) && (|rgb_q) && !in_active;

   always_comb begin
      state_d = state_q;
      case (state_q)
         SEARCH: begin
            if (v_as) state_d = ACQUIRE;
         end
         ACQUIRE: begin
            if (h_ev || v_ev)  state_d = SEARCH;
            else if (v_as)     state_d = LOCKED;
         end
         LOCKED: begin
            if (h_ev || v_ev)  state_d = SEARCH;
         end
         default: state_d = SEARCH;
      endcase

      locked_d    = (state_d == LOCKED);
      h_err_d     = (h_err_q     & ~clr_q) | h_ev;
      v_err_d     = (v_err_q     & ~clr_q) | v_ev;
      blank_err_d = (blank_err_q & ~clr_q) | blank_ev;

      frame_cnt_d = frame_cnt_q;
      if ((state_q == LOCKED) && v_as && v_len_ok) frame_cnt_d = frame_cnt_q + 8'd1;
   end

`ifdef VGA_COLOUR_CAPTURE_EN
   localparam logic [HW-1:0] H_CAP = HW'(H_START + H_ACTIVE / 2);
   localparam logic [VW-1:0] V_CAP = VW'(V_START + V_ACTIVE / 2);

   logic [2:0] colour_q, colour_d;

   always_comb begin
      colour_d = colour_q;
      if ((state_q == LOCKED) && (hcnt_d == H_CAP) && (vcnt_d == V_CAP)) colour_d = rgb_q;
   end

   assign colour_o = colour_q;
`else
   assign colour_o = 3'b000;
`endif

   always_ff @(posedge clk_main or negedge rst) begin
      if (!rst) begin
         state_q     <= SEARCH;
         hs_q        <= ~SYNC_POL;
         vs_q        <= ~SYNC_POL;
         hs_prev_q   <= ~SYNC_POL;
         vs_prev_q   <= ~SYNC_POL;
         rgb_q       <= 3'b000;
         clr_q       <= 1'b0;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         locked_q    <= 1'b0;
         h_err_q     <= 1'b0;
         v_err_q     <= 1'b0;
         blank_err_q <= 1'b0;
         frame_cnt_q <= 8'd0;
`ifdef VGA_COLOUR_CAPTURE_EN
         colour_q    <= 3'b000;
`endif
      end else begin
         state_q     <= state_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         hs_prev_q   <= hs_prev_d;
         vs_prev_q   <= vs_prev_d;
         rgb_q       <= rgb_d;
         clr_q       <= clr_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         locked_q    <= locked_d;
         h_err_q     <= h_err_d;
         v_err_q     <= v_err_d;
         blank_err_q <= blank_err_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef VGA_COLOUR_CAPTURE_EN
         colour_q    <= colour_d;
`endif
      end
   end

   assign locked_o    = locked_q;
   assign h_err_o     = h_err_q;
   assign v_err_o     = v_err_q;
   assign blank_err_o = blank_err_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule
